fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO-fed 8N1/8N2 UART transmitter: pops one byte per frame and serialises it LSB first.
// Optional even-parity bit between data and stop is enabled by defining FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       TX_EN,
    input  logic       F_EMPTY_N,
    input  logic [7:0] FIFO_DATA,
    output logic       FIFO_READ,
    output logic       TX,
    output logic       BUSY,
    output logic [7:0] TX_COUNT
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_START   = 3'd3;
    localparam logic [2:0] S_DATA    = 3'd4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY  = 3'd5;
`endif
    localparam logic [2:0] S_STOP    = 3'd6;

    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] count_q, count_d;
    logic       tx_q, tx_d;
    logic       read_q, read_d;
    logic       baud_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic       parity_q, parity_d;
`endif

    assign baud_end = (baud_q == BAUD_LAST);

    // The bit counter indexes data bits in DATA and is reused to count stop bits in STOP.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d  = state_q;
        baud_d   = baud_q + 8'd1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        count_d  = count_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = 8'd0;
                if (TX_EN && F_EMPTY_N) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                baud_d  = 8'd0;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                baud_d   = 8'd0;
                shift_d  = FIFO_DATA;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d = ^FIFO_DATA;
`endif
                state_d  = S_START;
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = 8'd0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = 8'd0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    baud_d  = 8'd0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    baud_d = 8'd0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = 3'd0;
                        count_d = count_q + 8'd1;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                baud_d  = 8'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        read_d = (state_d == S_FETCH);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // NOTE: the datapath registers (shift, counters) are reset too, so the block
    // restarts from a fully known state after an aborted frame.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            state_q  <= S_IDLE;
            baud_q   <= 8'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            count_q  <= 8'd0;
            tx_q     <= 1'b1;
            read_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            count_q  <= count_d;
            tx_q     <= tx_d;
            read_q   <= read_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign FIFO_READ = read_q;
    assign TX        = tx_q;
    assign BUSY      = (state_q != S_IDLE);
    assign TX_COUNT  = count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: stimulus queues bytes plus hand-computed parity,
// a monitor pops one entry per FIFO_READ pulse and checks the whole frame cycle by cycle.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_LEN = 46;
`else
    localparam int FRAME_LEN = 42;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tx_en = 1'b0;
    logic       f_empty_n = 1'b0;
    logic [7:0] fifo_data = 8'd0;
    logic       fifo_read;
    logic       tx;
    logic       busy;
    logic [7:0] tx_count;

    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];
    logic [7:0] cnt_exp = 8'd0;
    int         errors = 0;
    int         checks = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .CLOCK    (clock),
        .RESET    (reset),
        .TX_EN    (tx_en),
        .F_EMPTY_N(f_empty_n),
        .FIFO_DATA(fifo_data),
        .FIFO_READ(fifo_read),
        .TX       (tx),
        .BUSY     (busy),
        .TX_COUNT (tx_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic p);
        exp_t e;
        e.data = d;
        e.par  = p;
        fifo_q.push_back(d);
        exp_q.push_back(e);
        f_empty_n = 1'b1;
    endtask

    function automatic logic exp_tx(input exp_t e, input int k);
        int j;
        if (k < 2) return 1'b1;
        j = (k - 2) / CPB;
        if (j == 0) return 1'b0;
        if (j <= 8) return e.data[j-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (j == 9) return e.par;
`endif
        return 1'b1;
    endfunction

    task automatic wait_done(input int budget);
        int n = 0;
        @(negedge clock);
        while ((fifo_q.size() != 0 || busy) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("done_in_budget", 32'(n < budget), 1);
    endtask

    task automatic wait_read(input int budget);
        int n = 0;
        while (!fifo_read && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("read_seen", fifo_read, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("idle_seen", busy, 0);
    endtask

    // FIFO model: the pop happens while FIFO_READ is high, data is stable through CAPTURE.
    initial begin : fifo_model
        forever begin
            @(negedge clock);
            if (fifo_read && fifo_q.size() != 0) begin
                fifo_data = fifo_q.pop_front();
                f_empty_n = (fifo_q.size() != 0);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        bit   have;
        forever begin
            @(negedge clock);
            if (reset) begin
                cnt_exp = 8'd0;
            end else if (fifo_read) begin
                have = (exp_q.size() != 0);
                check("read_expected", 32'(have), 1);
                if (have) begin
                    e = exp_q.pop_front();
                    for (int k = 0; k <= FRAME_LEN; k++) begin
                        if (k > 0) @(negedge clock);
                        if (reset) begin
                            cnt_exp = 8'd0;
                            break;
                        end
                        if (k < FRAME_LEN) begin
                            check("frame_tx", tx, exp_tx(e, k));
                            check("frame_busy", busy, 1);
                            check("frame_read", fifo_read, 32'(k == 0));
                        end else begin
                            check("end_busy", busy, 0);
                            check("end_tx", tx, 1);
                            check("end_gap_read", fifo_read, 0);
                            cnt_exp = cnt_exp + 8'd1;
                            check("frame_tx_count", tx_count, cnt_exp);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] d;
        repeat (3) @(negedge clock);
        check("rst_tx", tx, 1);
        check("rst_read", fifo_read, 0);
        check("rst_busy", busy, 0);
        check("rst_count", tx_count, 0);
        reset = 1'b0;

        // Enabled but empty, then data present but disabled: nothing may start.
        tx_en = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check("empty_read", fifo_read, 0);
            check("empty_busy", busy, 0);
        end
        tx_en = 1'b0;
        push(8'hA5, 1'b0);
        repeat (5) begin
            @(negedge clock);
            check("disabled_busy", busy, 0);
            check("disabled_read", fifo_read, 0);
        end
        tx_en = 1'b1;
        wait_done(200);
        check("count_a5", tx_count, 1);

        push(8'h07, 1'b1);
        wait_done(200);
        check("count_07", tx_count, 2);

        push(8'h01, 1'b1);
        push(8'h02, 1'b1);
        push(8'h03, 1'b0);
        wait_done(400);
        check("count_three", tx_count, 5);
        repeat (10) begin
            @(negedge clock);
            check("drained_read", fifo_read, 0);
        end

        // TX_EN dropped in the middle of the data bits of the first of two frames.
        push(8'h3C, 1'b0);
        push(8'hC3, 1'b0);
        wait_read(50);
        repeat (10) @(negedge clock);
        tx_en = 1'b0;
        wait_idle(100);
        repeat (20) begin
            @(negedge clock);
            check("paused_tx", tx, 1);
            check("paused_read", fifo_read, 0);
        end
        check("paused_fifo_left", 32'(fifo_q.size()), 1);
        check("paused_count", tx_count, 6);
        tx_en = 1'b1;
        wait_done(200);
        check("count_resumed", tx_count, 7);

        // Reset during data bit 3 of the 0x55 frame; 0x96 is sent after release.
        push(8'h55, 1'b0);
        push(8'h96, 1'b0);
        wait_read(50);
        repeat (19) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_count", tx_count, 0);
        check("abort_read", fifo_read, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("restart_read", fifo_read, 1);
        check("restart_busy", busy, 1);
        wait_done(200);
        check("count_after_abort", tx_count, 1);

        // 260 frames from a fresh reset: the 8-bit count wraps to 4.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst2_count", tx_count, 0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 260; i++) begin
            d = 8'(i * 7 + 3);
            push(d, ^d);
        end
        wait_done(260 * 50);
        check("count_wrap", tx_count, 4);

        repeat (5) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
